load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_load_store_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit for an RV32I core: accepts one memory request at a time,
// checks alignment/range/encoding, performs word reads and writes against a
// combinational-read data memory and returns an extended load result.
// Sub-word stores are done as read-modify-write of the containing word.
module load_store_unit #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [15:0] wdata_q;      // only the low halfword is needed for merging
   logic [31:0] rdata_q;
   logic        err_q;
   logic        mem_we_q;
   logic [31:0] mem_wdata_q;  // full store word, or merged word for SB/SH
   logic        ready_q;
   logic        valid_q;

   // Illegal encoding, misalignment or out-of-range word index.
   function automatic logic access_err(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr);
      logic illegal;
      logic misaligned;
      logic out_of_range;
      if (we)
         illegal = f3[2] | (f3[1:0] == 2'b11);
      else
         illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
      misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                     ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      out_of_range = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
      return illegal | misaligned | out_of_range;
   endfunction

   // Select the addressed byte/halfword/word and extend it.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [2:0] f3,
                                                input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'h000000, b};
         3'b101:  r = {16'h0000, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the byte lanes targeted by a sub-word store.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [15:0] wd,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
      logic [31:0] m;
      m = word;
      if (f3 == 3'b000) begin
         case (off)
            2'd0:    m[7:0]   = wd[7:0];
            2'd1:    m[15:8]  = wd[7:0];
            2'd2:    m[23:16] = wd[7:0];
            default: m[31:24] = wd[7:0];
         endcase
      end else begin
         if (off[1])
            m[31:16] = wd;
         else
            m[15:0]  = wd;
      end
      return m;
   endfunction

   // Request sequencing FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= 32'h0;
         wdata_q     <= 16'h0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= 32'h0;
         ready_q     <= 1'b1;
         valid_q     <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata[15:0];
                  rdata_q  <= 32'h0;
                  ready_q  <= 1'b0;
                  if (access_err(req_we, req_funct3, req_addr)) begin
                     err_q   <= 1'b1;
                     valid_q <= 1'b1;
                     state_q <= RESP;
                  end else begin
                     err_q <= 1'b0;
                     if (req_we && (req_funct3 == 3'b010)) begin
                        mem_wdata_q <= req_wdata;
                        mem_we_q    <= 1'b1;
                        state_q     <= WR;
                     end else begin
                        state_q <= RD;
                     end
                  end
               end
            end
            RD: begin
               if (we_q) begin
                  mem_wdata_q <= store_merge(mem_rdata, wdata_q, funct3_q, addr_q[1:0]);
                  mem_we_q    <= 1'b1;
                  state_q     <= WR;
               end else begin
                  rdata_q <= load_extract(mem_rdata, funct3_q, addr_q[1:0]);
                  valid_q <= 1'b1;
                  state_q <= RESP;
               end
            end
            WR: begin
               valid_q <= 1'b1;
               state_q <= RESP;
            end
            default: begin
               if (resp_ready) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

   localparam int MEM_WORDS = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [MEM_WORDS];
   logic        poke_en;
   int          poke_idx;
   logic [31:0] poke_val;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          writes;
      logic [31:0] wword;
      logic [31:0] sum;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Memory model: combinational read, write on rising edge, bench preload port
   assign mem_rdata = ({2'b00, mem_addr[31:2]} < 32'(MEM_WORDS)) ?
                      mem[int'(mem_addr[31:2])] : 32'hDEADBEEF;

   always @(posedge clk) begin
      if (poke_en)
         mem[poke_idx] <= poke_val;
      else if (mem_we && ({2'b00, mem_addr[31:2]} < 32'(MEM_WORDS)))
         mem[int'(mem_addr[31:2])] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_sum();
      logic [31:0] s = 32'h0;
      for (int i = 0; i < MEM_WORDS; i++) s = s + mem[i];
      return s;
   endfunction

   task automatic poke(input int idx, input logic [31:0] val);
      @(negedge clk);
      poke_en  = 1'b1;
      poke_idx = idx;
      poke_val = val;
      @(negedge clk);
      poke_en  = 1'b0;
   endtask

   // Issue one request, score its response, memory traffic and final memory state.
   task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, output logic [31:0] got);
      exp_t        e;
      exp_t        r;
      logic        legal;
      logic        inr;
      int          idx;
      int          sh;
      logic [31:0] old;
      logic [31:0] v;
      logic [31:0] msk;
      int          lat;
      int          writes;
      int          we_cyc;
      logic [31:0] wseen;

      idx   = int'(addr[31:2]);
      inr   = (idx < MEM_WORDS);
      old   = inr ? mem[idx] : 32'h0;
      sh    = int'(addr[1:0]) * 8;
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      e.err = !legal || !inr || ((f3[1:0] == 2'b01) && addr[0]) ||
              ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      e.rdata  = 32'h0;
      e.wword  = old;
      e.writes = 0;
      e.sum    = mem_sum();
      if (e.err) begin
         e.lat = 1;
      end else if (!we) begin
         e.lat = 2;
         v = old >> sh;
         case (f3)
            3'd0: e.rdata = (v & 32'hFF)   | (v[7]  ? 32'hFFFFFF00 : 32'h0);
            3'd1: e.rdata = (v & 32'hFFFF) | (v[15] ? 32'hFFFF0000 : 32'h0);
            3'd4: e.rdata = v & 32'hFF;
            3'd5: e.rdata = v & 32'hFFFF;
            default: e.rdata = old;
         endcase
      end else begin
         e.lat    = (f3 == 3'd2) ? 2 : 3;
         msk      = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF;
         e.wword  = (old & ~(msk << sh)) | ((wd & msk) << sh);
         e.writes = 1;
         e.sum    = e.sum - old + e.wword;
      end
      sb.push_back(e);

      @(negedge clk);
      chk({tag, "/req_ready"}, {31'h0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(negedge clk);
      req_valid = 1'b0;
      lat    = 1;
      writes = 0;
      we_cyc = 0;
      wseen  = 32'h0;
      forever begin
         if (mem_we) begin
            writes++;
            we_cyc = lat;
            wseen  = mem_wdata;
         end
         if (resp_valid || lat >= 8) break;
         @(negedge clk);
         lat++;
      end
      r = sb.pop_front();
      chk({tag, "/latency"}, 32'(lat), 32'(r.lat));
      chk({tag, "/resp_err"}, {31'h0, resp_err}, {31'h0, r.err});
      chk({tag, "/resp_rdata"}, resp_rdata, r.rdata);
      chk({tag, "/mem_we_pulses"}, 32'(writes), 32'(r.writes));
      if (r.writes == 1) begin
         chk({tag, "/mem_we_cycle"}, 32'(we_cyc), 32'(r.lat - 1));
         chk({tag, "/mem_wdata"}, wseen, r.wword);
      end
      got = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "/hold_valid"}, {31'h0, resp_valid}, 32'd1);
         chk({tag, "/hold_ready"}, {31'h0, req_ready}, 32'd0);
         chk({tag, "/hold_rdata"}, resp_rdata, r.rdata);
         chk({tag, "/hold_err"}, {31'h0, resp_err}, {31'h0, r.err});
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, "/idle_ready"}, {31'h0, req_ready}, 32'd1);
      chk({tag, "/idle_valid"}, {31'h0, resp_valid}, 32'd0);
      if (inr) chk({tag, "/mem_word"}, mem[idx], r.wword);
      chk({tag, "/mem_sum"}, mem_sum(), r.sum);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;
      poke_en    = 1'b0;
      poke_idx   = 0;
      poke_val   = 32'h0;
      #1;
      chk("rst/resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("rst/resp_rdata", resp_rdata, 32'h0);
      chk("rst/resp_err", {31'h0, resp_err}, 32'd0);
      chk("rst/mem_we", {31'h0, mem_we}, 32'd0);
      chk("rst/mem_addr", mem_addr, 32'h0);
      chk("rst/mem_wdata", mem_wdata, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst/req_ready", {31'h0, req_ready}, 32'd1);

      for (int i = 0; i < MEM_WORDS; i++) poke(i, $urandom);

      // Loads with sign and zero extension
      poke(4, 32'h11223344);
      run_req("lb13", 1'b0, 3'd0, 32'h13, 32'h0, 0, got);
      chk("lb13/value", got, 32'h00000011);
      poke(4, 32'h000000F0);
      run_req("lb10", 1'b0, 3'd0, 32'h10, 32'h0, 0, got);
      chk("lb10/value", got, 32'hFFFFFFF0);
      run_req("lbu10", 1'b0, 3'd4, 32'h10, 32'h0, 0, got);
      chk("lbu10/value", got, 32'h000000F0);

      // Halfword read-modify-write
      poke(8, 32'hAABBCCDD);
      run_req("sh22", 1'b1, 3'd1, 32'h22, 32'h00001234, 0, got);
      chk("sh22/word", mem[8], 32'h1234CCDD);
      chk("sh22/rdata", got, 32'h0);

      // Error cases
      run_req("lw06", 1'b0, 3'd2, 32'h06, 32'h0, 0, got);
      run_req("sh05", 1'b1, 3'd1, 32'h05, 32'hBEEF, 0, got);
      run_req("sw_oor", 1'b1, 3'd2, 32'(4 * MEM_WORDS), 32'h12345678, 0, got);
      run_req("f3_011", 1'b0, 3'd3, 32'h20, 32'h0, 0, got);
      run_req("sb_f3_4", 1'b1, 3'd4, 32'h20, 32'h0, 0, got);

      // Back-pressure on the response
      run_req("lw20_hold", 1'b0, 3'd2, 32'h20, 32'h0, 5, got);
      chk("lw20_hold/value", got, 32'h1234CCDD);

      // Other size/offset combinations
      run_req("lh22", 1'b0, 3'd1, 32'h22, 32'h0, 0, got);
      run_req("sw24", 1'b1, 3'd2, 32'h24, 32'hCAFEBABE, 1, got);
      run_req("lw24", 1'b0, 3'd2, 32'h24, 32'h0, 0, got);
      chk("lw24/value", got, 32'hCAFEBABE);
      run_req("sb21", 1'b1, 3'd0, 32'h21, 32'h77, 0, got);
      run_req("lhu20", 1'b0, 3'd5, 32'h20, 32'h0, 0, got);
      run_req("lw_last", 1'b0, 3'd2, 32'(4 * MEM_WORDS - 4), 32'h0, 0, got);

      // Randomised mix
      for (int i = 0; i < 40; i++) begin
         run_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 32'($urandom_range(0, 4 * MEM_WORDS + 15)), $urandom,
                 $urandom_range(0, 2), got);
      end

      // Reset during the read phase of a byte store
      poke(12, 32'h55667788);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd0;
      req_addr   = 32'h31;
      req_wdata  = 32'hAA;
      @(negedge clk);
      req_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("rstrd/mem_we", {31'h0, mem_we}, 32'd0);
      chk("rstrd/resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("rstrd/mem_addr", mem_addr, 32'h0);
      chk("rstrd/mem_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstrd/no_write", {31'h0, mem_we}, 32'd0);
         chk("rstrd/idle", {31'h0, req_ready}, 32'd1);
      end
      chk("rstrd/word", mem[12], 32'h55667788);
      run_req("lw30_after_rst", 1'b0, 3'd2, 32'h30, 32'h0, 0, got);
      chk("lw30_after_rst/value", got, 32'h55667788);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
